// File: rtl/int_to_float_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : int_to_float_pipe_if
// Brief    : Valid/ready bundle for the integer-to-float conversion pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface int_to_float_pipe_if #(
    parameter int IN_W  = 24,
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int c_OUT_W = 1 + EXP_W + MAN_W;

    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               in_round;
    logic               out_valid;
    logic               out_ready;
    logic [c_OUT_W-1:0] out_data;
    logic               out_inexact;
    logic               out_overflow;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, in_data, in_round, out_ready,
        input  in_ready, out_valid, out_data, out_inexact, out_overflow
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, in_round, out_ready,
        output in_ready, out_valid, out_data, out_inexact, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/int_to_float_pipe.sv
`default_nettype none
// ============================================================================
// Module   : int_to_float_pipe
// Brief    : 3-stage signed-integer to packed-float converter with RNE/trunc.
// Revision : 1.0 - initial release
// ============================================================================
module int_to_float_pipe #(
    parameter int IN_W     = 24,
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int EXP_BIAS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    int_to_float_pipe_if.slave   bus
);
    localparam int          c_OUT_W   = 1 + EXP_W + MAN_W;
    localparam int          c_P_W     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int          c_EXT_W   = IN_W + MAN_W + 1;
    localparam logic [31:0] c_EXP_MAX = 32'((64'd1 << EXP_W) - 64'd1);

    // Stage enables: a stage loads when empty or when its successor moves on
    logic w_s1_en, w_s2_en, w_s3_en;

    logic               r_s1_valid, r_s1_sign, r_s1_round;
    logic [IN_W-1:0]    r_s1_mag;

    logic               r_s2_valid, r_s2_sign, r_s2_zero, r_s2_round;
    logic [c_P_W-1:0]   r_s2_p;
    logic [MAN_W-1:0]   r_s2_man;
    logic               r_s2_guard, r_s2_sticky;

    logic               r_s3_valid, r_s3_inexact, r_s3_overflow;
    logic [c_OUT_W-1:0] r_s3_data;

    assign w_s3_en = !r_s3_valid || bus.out_ready;
    assign w_s2_en = !r_s2_valid || w_s3_en;
    assign w_s1_en = !r_s1_valid || w_s2_en;

    assign bus.in_ready     = w_s1_en;
    assign bus.out_valid    = r_s3_valid;
    assign bus.out_data     = r_s3_data;
    assign bus.out_inexact  = r_s3_inexact;
    assign bus.out_overflow = r_s3_overflow;

    // S1: sign and magnitude; the most negative input wraps to 2^(IN_W-1)
    logic [IN_W-1:0] w_abs;
    assign w_abs = bus.in_data[IN_W-1] ? -bus.in_data : bus.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_round <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sign  <= bus.in_data[IN_W-1];
            r_s1_round <= bus.in_round;
            r_s1_mag   <= w_abs;
        end
    end

    // S2: leading-one detect and normalise into an extended field
    logic [c_P_W-1:0]   w_p;
    logic [c_P_W-1:0]   w_shamt;
    logic [c_EXT_W-1:0] w_ext;

    always_comb begin
        w_p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (r_s1_mag[i]) begin
                w_p = c_P_W'(i);
            end
        end
        w_shamt = c_P_W'(IN_W - 1) - w_p;
        w_ext   = {r_s1_mag, {(MAN_W + 1){1'b0}}} << w_shamt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_round  <= 1'b0;
            r_s2_p      <= '0;
            r_s2_man    <= '0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_sign   <= r_s1_sign;
            r_s2_zero   <= (r_s1_mag == '0);
            r_s2_round  <= r_s1_round;
            r_s2_p      <= w_p;
            r_s2_man    <= w_ext[c_EXT_W-2 -: MAN_W];
            r_s2_guard  <= w_ext[c_EXT_W-2-MAN_W];
            r_s2_sticky <= |w_ext[c_EXT_W-3-MAN_W:0];
        end
    end

    // S3: round, carry into exponent, saturate, pack
    logic               w_inc;
    logic [MAN_W:0]     w_man_sum;
    logic [31:0]        w_exp_full;
    logic               w_ovf;
    logic [c_OUT_W-1:0] w_res;
    logic               w_res_inexact, w_res_ovf;

    assign w_inc      = r_s2_round & r_s2_guard & (r_s2_sticky | r_s2_man[0]);
    assign w_man_sum  = {1'b0, r_s2_man} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_full = 32'(EXP_BIAS) + 32'(r_s2_p) + 32'(w_man_sum[MAN_W]);
    assign w_ovf      = (w_exp_full > c_EXP_MAX);

    always_comb begin
        w_res         = {r_s2_sign, w_exp_full[EXP_W-1:0], w_man_sum[MAN_W-1:0]};
        w_res_inexact = r_s2_guard | r_s2_sticky;
        w_res_ovf     = w_ovf;
        if (r_s2_zero) begin
            w_res         = '0;
            w_res_inexact = 1'b0;
            w_res_ovf     = 1'b0;
        end else if (w_ovf) begin
            w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid    <= 1'b0;
            r_s3_data     <= '0;
            r_s3_inexact  <= 1'b0;
            r_s3_overflow <= 1'b0;
        end else if (w_s3_en) begin
            r_s3_valid    <= r_s2_valid;
            r_s3_data     <= w_res;
            r_s3_inexact  <= w_res_inexact;
            r_s3_overflow <= w_res_ovf;
        end
    end
endmodule
`default_nettype wire
